// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg
//   Shared types for the RAM march-test BIST controller.
//   - bist_state_e : controller phases, one per march element plus DRAIN and DONE
//   - march_op_t   : what the current cycle does on the RAM port {rd, wr, inv}
//   - ERR_W        : width of the saturating mismatch counter
//   - march_op()   : decodes (state, phase) into the RAM operation for that cycle

package ram_bist_pkg;

    localparam int ERR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        W_INIT,
        RW_UP,
        RW_DN,
        R_FIN,
        DRAIN,
        DONE
    } bist_state_e;

    typedef struct packed {
        logic rd;   // read and compare this cycle
        logic wr;   // write this cycle
        logic inv;  // data is ~PATTERN instead of PATTERN
    } march_op_t;

    // RW_UP and RW_DN take two cycles per address: phase 0 reads, phase 1 writes.
    function automatic march_op_t march_op(input bist_state_e st, input logic phase);
        march_op_t op;
        op = '0;
        case (st)
            W_INIT: op.wr = 1'b1;
            RW_UP: begin
                if (!phase) begin
                    op.rd = 1'b1;
                end else begin
                    op.wr  = 1'b1;
                    op.inv = 1'b1;
                end
            end
            RW_DN: begin
                if (!phase) begin
                    op.rd  = 1'b1;
                    op.inv = 1'b1;
                end else begin
                    op.wr = 1'b1;
                end
            end
            R_FIN:   op.rd = 1'b1;
            default: op = '0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// ram_bist_checker
//   Compare pipeline for the march test. Each issued read pushes {valid, expected,
//   address} into a RD_LATENCY+1 deep shift register that runs in parallel with the
//   registered RAM drivers, so the last stage lines up with ram_dout_i.
//   Ports:
//     clk, rst           clock, asynchronous active-high reset
//     clr_i              clear results at the start of a new test
//     vld_i/exp_i/addr_i read being issued this cycle, its expected data and address
//     ram_dout_i         RAM read data
//     err_count_o        saturating mismatch count
//     fail_addr_o        address of the first mismatch (0 if none)
//     mismatch_o         a valid compare slot disagrees with ram_dout_i this cycle

module ram_bist_checker
    import ram_bist_pkg::*;
#(
    parameter int AW         = 6,
    parameter int DW         = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             vld_i,
    input  logic [DW-1:0]    exp_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [DW-1:0]    ram_dout_i,
    output logic [ERR_W-1:0] err_count_o,
    output logic [AW-1:0]    fail_addr_o,
    output logic             mismatch_o
);

    localparam int DEPTH = RD_LATENCY + 1;

    logic [DEPTH-1:0] vld_q;
    logic [DW-1:0]    exp_q [DEPTH];
    logic [AW-1:0]    tag_q [DEPTH];
    logic [ERR_W-1:0] err_q, err_d;
    logic [AW-1:0]    fail_q, fail_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            err_q  <= '0;
            fail_q <= '0;
        end else begin
            vld_q  <= clr_i ? '0 : {vld_q[DEPTH-2:0], vld_i};
            err_q  <= err_d;
            fail_q <= fail_d;
        end
    end

    // NOTE: data/address stages carry no reset; they are only ever looked at
    // through their valid bit, so resetting them would buy nothing.
    always_ff @(posedge clk) begin
        exp_q[0] <= exp_i;
        tag_q[0] <= addr_i;
        for (int i = 1; i < DEPTH; i++) begin
            exp_q[i] <= exp_q[i-1];
            tag_q[i] <= tag_q[i-1];
        end
    end

    assign mismatch_o = vld_q[DEPTH-1] && (ram_dout_i != exp_q[DEPTH-1]);

    always_comb begin
        err_d  = err_q;
        fail_d = fail_q;
        if (clr_i) begin
            err_d  = '0;
            fail_d = '0;
        end else if (mismatch_o) begin
            // Counter never wraps, so zero means "no mismatch seen yet".
            if (err_q == '0) fail_d = tag_q[DEPTH-1];
            if (err_q != '1) err_d  = err_q + 1'b1;
        end
    end

    assign err_count_o = err_q;
    assign fail_addr_o = fail_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl
//   March-test BIST initiator for a single-port RAM. Sequence:
//   W_INIT (w P up), RW_UP (r P, w ~P up), RW_DN (r ~P, w P down), R_FIN (r P up),
//   then DRAIN flushes the compare pipeline and DONE holds the result.
//   The FSM prepares one op per cycle; the RAM pins are registered copies of it.
//   Build option: define BIST_STOP_ON_FAIL_EN to abort into DRAIN on the first mismatch.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     start                 1-cycle request, honoured only in IDLE or DONE
//     busy, done, pass      run status; pass = done with zero mismatches
//     err_count, fail_addr  saturating mismatch count, first failing address
//     ram_we/addr/din       registered RAM drivers
//     ram_dout              RAM read data

module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int            AW         = 6,
    parameter int            DW         = 8,
    parameter int            RD_LATENCY = 1,
    parameter logic [DW-1:0] PATTERN    = 8'h55
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [AW-1:0]    fail_addr,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    input  logic [DW-1:0]    ram_dout
);

`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [AW-1:0] ADDR_MAX = '1;
    localparam int            DCW      = $clog2(RD_LATENCY + 1) + 1;

    bist_state_e    state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           phase_q, phase_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic           busy_q, busy_d;
    logic           clr;
    logic           ram_we_q;
    logic [AW-1:0]  ram_addr_q;
    logic [DW-1:0]  ram_din_q;
    logic           mismatch;
    march_op_t      cur_op;
    logic [DW-1:0]  cur_data;

    assign cur_op   = march_op(state_q, phase_q);
    assign cur_data = cur_op.inv ? ~PATTERN : PATTERN;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_d = state_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        drain_d = drain_q;
        clr     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = W_INIT;
                    addr_d  = '0;
                    phase_d = 1'b0;
                    clr     = 1'b1;
                end
            end
            W_INIT: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = RW_UP;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            RW_UP: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (addr_q == ADDR_MAX) state_d = RW_DN;  // descend from the top
                    else                    addr_d  = addr_q + 1'b1;
                end
            end
            RW_DN: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (addr_q == '0) state_d = R_FIN;        // ascend from address 0
                    else              addr_d  = addr_q - 1'b1;
                end
            end
            R_FIN: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DCW'(RD_LATENCY)) state_d = DONE;
                else                             drain_d = drain_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (STOP_ON_FAIL && mismatch && (state_q inside {W_INIT, RW_UP, RW_DN, R_FIN})) begin
            state_d = DRAIN;
            drain_d = '0;
        end

        // Rises one edge after the start edge and drops on the edge done rises.
        busy_d = (state_q != IDLE) && (state_q != DONE) && (state_d != DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            phase_q    <= 1'b0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            ram_we_q   <= cur_op.wr;
            ram_addr_q <= addr_q;
            if (cur_op.wr) ram_din_q <= cur_data;
        end
    end

    // Read slots enter the checker on the same edge the op reaches the RAM pins.
    ram_bist_checker #(
        .AW         (AW),
        .DW         (DW),
        .RD_LATENCY (RD_LATENCY)
    ) u_checker (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr),
        .vld_i       (cur_op.rd),
        .exp_i       (cur_data),
        .addr_i      (addr_q),
        .ram_dout_i  (ram_dout),
        .err_count_o (err_count),
        .fail_addr_o (fail_addr),
        .mismatch_o  (mismatch)
    );

    assign busy     = busy_q;
    assign done     = (state_q == DONE);
    assign pass     = done && (err_count == '0);
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl
//   Two controllers: a default one (AW=6) on a RAM with injectable stuck-at bits,
//   and an AW=8 one on a RAM whose every cell reads 8'h00. Expected results come
//   from a march-walk model over a plain array and are queued at start; monitors
//   pop and compare when done rises.

module tb_ram_bist_ctrl;

    localparam int          N  = 64;
    localparam int          N8 = 256;
    localparam int          L  = 1;
    localparam logic [7:0]  P  = 8'h55;
`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        logic [7:0]  err;
        int          fa;
        logic        pass;
        int unsigned done_cyc;
    } exp_t;

    typedef struct {
        bit         rd;
        int         a;
        logic [7:0] d;
    } mop_t;

    logic       clk, rst, start, start8;
    logic       busy, done, pass, ram_we;
    logic [7:0] err_count, ram_din, dout_a;
    logic [5:0] fail_addr, ram_addr;
    logic       busy8, done8, pass8, ram_we8;
    logic [7:0] err_count8, ram_din8, dout_b;
    logic [7:0] fail_addr8, ram_addr8;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb_a[$];
    exp_t        sb_b[$];
    exp_t        e_mon_a, e_mon_b;
    logic        done_prev_a = 1'b0;
    logic        done_prev_b = 1'b0;

    logic [7:0] mem_a [N];
    logic [7:0] sa1 [N];
    logic [7:0] sa0 [N];

    ram_bist_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_addr(fail_addr), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(dout_a)
    );

    ram_bist_ctrl #(.AW(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8), .pass(pass8),
        .err_count(err_count8), .fail_addr(fail_addr8), .ram_we(ram_we8),
        .ram_addr(ram_addr8), .ram_din(ram_din8), .ram_dout(dout_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM, one cycle read latency, stuck-at faults applied on read.
    always @(posedge clk) begin
        if (ram_we) mem_a[ram_addr] <= ram_din;
        dout_a <= (mem_a[ram_addr] | sa1[ram_addr]) & ~sa0[ram_addr];
    end

    // Every cell of the wide RAM is stuck at zero.
    always @(posedge clk) dout_b <= 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Walks the march over an array; with STOP the ops issued up to L+1 after the
    // first failing one still complete and are counted.
    task automatic model(input int n, input bit zero_ram, output exp_t e, output int lat);
        mop_t       ops[$];
        logic [7:0] m [N8];
        logic [7:0] rv;
        int         errs = 0;
        int         first = -1;
        int         k = 0;
        int         limit;
        for (int a = 0; a < n; a++)      ops.push_back('{0, a, P});
        for (int a = 0; a < n; a++) begin ops.push_back('{1, a, P});  ops.push_back('{0, a, ~P}); end
        for (int a = n - 1; a >= 0; a--) begin ops.push_back('{1, a, ~P}); ops.push_back('{0, a, P}); end
        for (int a = 0; a < n; a++)      ops.push_back('{1, a, P});
        limit = ops.size() - 1;
        for (int j = 0; j < ops.size(); j++) begin
            if (j > limit) break;
            if (!ops[j].rd) begin
                m[ops[j].a] = ops[j].d;
            end else begin
                if (zero_ram) rv = 8'h00;
                else          rv = (m[ops[j].a] | sa1[ops[j].a]) & ~sa0[ops[j].a];
                if (rv !== ops[j].d) begin
                    errs++;
                    if (first < 0) begin
                        first = ops[j].a;
                        k     = j;
                        if (STOP) limit = j + L + 1;
                    end
                end
            end
        end
        lat        = (STOP && first >= 0) ? k + 2 * L + 3 : 6 * n + L + 1;
        e.err      = (errs > 255) ? 8'hFF : 8'(errs);
        e.fa       = (first < 0) ? 0 : first;
        e.pass     = (errs == 0);
        e.done_cyc = 0;
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            sa1[i] = 8'h00;
            sa0[i] = 8'h00;
        end
    endtask

    task automatic issue_start_a();
        exp_t e;
        int   lat;
        model(N, 1'b0, e, lat);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("clr_done", done, 0);
        check("clr_err_count", err_count, 0);
        check("clr_fail_addr", fail_addr, 0);
        check("clr_pass", pass, 0);
        e.done_cyc = cyc + lat;
        sb_a.push_back(e);
        @(negedge clk);
        check("busy_after_start", busy, 1);
    endtask

    task automatic pulse_start_a();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_a(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb_a.size() == 0) break;
            @(negedge clk);
        end
        if (sb_a.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_a: done not seen within %0d cycles", budget);
            sb_a.delete();
        end
    endtask

    task automatic wait_b(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb_b.size() == 0) break;
            @(negedge clk);
        end
        if (sb_b.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_b: done not seen within %0d cycles", budget);
            sb_b.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (!done) check("pass_low_while_not_done", pass, 0);
            if (!busy) check("we_low_while_not_busy", ram_we, 0);
            if (done && !done_prev_a) begin
                if (sb_a.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done_a: done rose with nothing expected at cycle %0d", cyc);
                end else begin
                    e_mon_a = sb_a.pop_front();
                    check("err_count", err_count, e_mon_a.err);
                    check("fail_addr", fail_addr, e_mon_a.fa);
                    check("pass", pass, e_mon_a.pass);
                    check("done_cycle", cyc, e_mon_a.done_cyc);
                    check("busy_low_at_done", busy, 0);
                end
            end
        end
        done_prev_a <= done;
    end

    always @(negedge clk) begin
        if (!rst && done8 && !done_prev_b) begin
            if (sb_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done_b: done rose with nothing expected at cycle %0d", cyc);
            end else begin
                e_mon_b = sb_b.pop_front();
                check("err_count_aw8", err_count8, e_mon_b.err);
                check("fail_addr_aw8", fail_addr8, e_mon_b.fa);
                check("pass_aw8", pass8, e_mon_b.pass);
                check("done_cycle_aw8", cyc, e_mon_b.done_cyc);
            end
        end
        done_prev_b <= done8;
    end

    initial begin
        exp_t e8;
        int   lat8;
        int   fa_addr;
        int   fa_bit;

        rst    = 1'b0;
        start  = 1'b0;
        start8 = 1'b0;
        clear_faults();
        #1 rst = 1'b1;
        #2;
        check("rst_ram_we", ram_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_count", err_count, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Fault-free RAM.
        issue_start_a();
        wait_a(1000);

        // Single stuck-at-1 on bit 0 of address 10, started from DONE.
        sa1[10] = 8'h01;
        issue_start_a();
        wait_a(1000);

        // Rerun the same fault with start pulses landing mid-run.
        issue_start_a();
        repeat (50) @(negedge clk);
        pulse_start_a();
        repeat (100) @(negedge clk);
        pulse_start_a();
        wait_a(1000);

        // Random single-bit stuck-at faults.
        for (int it = 0; it < 5; it++) begin
            clear_faults();
            fa_addr = $urandom_range(0, N - 1);
            fa_bit  = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) sa1[fa_addr] = 8'(1 << fa_bit);
            else                           sa0[fa_addr] = 8'(1 << fa_bit);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            issue_start_a();
            wait_a(1000);
        end

        // Reset in the middle of a run, then a clean rerun.
        clear_faults();
        issue_start_a();
        repeat (97) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_ram_we", ram_we, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        sb_a.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        issue_start_a();
        wait_a(1000);

        // AW=8, all cells stuck at zero: counter saturation.
        model(N8, 1'b1, e8, lat8);
        @(negedge clk) start8 = 1'b1;
        @(negedge clk) start8 = 1'b0;
        e8.done_cyc = cyc + lat8;
        sb_b.push_back(e8);
        wait_b(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
